// File: rtl/ao_spc_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ SPC register-bus masters onto the AOPB external slot.
// Define AO_SPC_ARB_TIMEOUT_EN to build in the transfer watchdog (otherwise GRANT waits forever).

package ao_spc_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

endpackage

module ao_spc_arbiter
  import ao_spc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_gen,
  input  logic                     rst_n,
  input  reg_req_t [NUM_REQ-1:0]   spc_req_i,
  output reg_rsp_t [NUM_REQ-1:0]   spc_rsp_o,
  output reg_req_t                 aopb_req_o,
  input  reg_rsp_t                 aopb_rsp_i,
  output logic     [NUM_REQ-1:0]   grant_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] winner, cand;
  logic            any_valid;
  logic            complete;

`ifdef AO_SPC_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // First valid index searched upward from the one after the last winner.
  always_comb begin
    winner    = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_REQ);
      if (!any_valid && spc_req_i[cand].valid) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    spc_rsp_o  = '0;
    aopb_req_o = '0;
    grant_o    = '0;
    busy_o     = 1'b0;
    timeout_o  = 1'b0;
    complete   = 1'b0;
`ifdef AO_SPC_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          state_d = StGrant;
          owner_d = winner;
`ifdef AO_SPC_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      StGrant: begin
        busy_o              = 1'b1;
        grant_o[owner_q]    = 1'b1;
        aopb_req_o          = spc_req_i[owner_q];
        spc_rsp_o[owner_q]  = aopb_rsp_i;
        complete            = spc_req_i[owner_q].valid & aopb_rsp_i.ready;
        // Completion wins over a watchdog expiry in the same cycle.
        if (complete || !spc_req_i[owner_q].valid) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
`ifdef AO_SPC_ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES)) begin
          spc_rsp_o[owner_q] = '{ready: 1'b1, rdata: 32'h0, error: 1'b1};
          aopb_req_o.valid   = 1'b0;
          timeout_o          = 1'b1;
          state_d            = StIdle;
          last_d             = owner_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef AO_SPC_ARB_TIMEOUT_EN
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ao_spc_arbiter.sv
// Self-checking bench for ao_spc_arbiter: directed scenarios plus randomized masters and slave,
// all compared cycle by cycle against a behavioural model of the arbitration rules.

module tb_ao_spc_arbiter;
  import ao_spc_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 4;

  logic                 clk_gen = 1'b0;
  logic                 rst_n;
  reg_req_t [N-1:0]     spc_req;
  reg_rsp_t [N-1:0]     spc_rsp;
  reg_req_t             aopb_req;
  reg_rsp_t             aopb_rsp;
  logic     [N-1:0]     grant;
  logic                 busy;
  logic                 tout;

  ao_spc_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk_gen   (clk_gen),
    .rst_n     (rst_n),
    .spc_req_i (spc_req),
    .spc_rsp_o (spc_rsp),
    .aopb_req_o(aopb_req),
    .aopb_rsp_i(aopb_rsp),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (tout)
  );

  always #5 clk_gen = ~clk_gen;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current owner (-1 when nobody holds the bus), last winner, watchdog count.
  int m_owner, m_last, m_cnt;
  int m_done;
  int to_seen;
  logic [N-1:0] obs_gnt;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    m_done  = -1;
  endtask

  // One clock cycle: predict outputs at the negedge, compare, then advance the model.
  task automatic step();
    reg_req_t         e_req;
    reg_rsp_t [N-1:0] e_rsp;
    logic     [N-1:0] e_gnt;
    logic             e_busy, e_to;
    int               n_owner, n_last, n_cnt;
    @(negedge clk_gen);
    e_req = '0; e_rsp = '0; e_gnt = '0; e_busy = 1'b0; e_to = 1'b0;
    n_owner = m_owner; n_last = m_last; n_cnt = m_cnt; m_done = -1;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_last + k) % N;
        if (n_owner < 0 && spc_req[idx].valid) begin
          n_owner = idx;
          n_cnt   = 0;
        end
      end
    end else begin
      e_gnt[m_owner] = 1'b1;
      e_busy         = 1'b1;
      e_req          = spc_req[m_owner];
      e_rsp[m_owner] = aopb_rsp;
      if (spc_req[m_owner].valid && aopb_rsp.ready) begin
        n_owner = -1; n_last = m_owner; m_done = m_owner;
      end else if (!spc_req[m_owner].valid) begin
        n_owner = -1; n_last = m_owner;
      end
`ifdef AO_SPC_ARB_TIMEOUT_EN
      else if (m_cnt == TO) begin
        e_rsp[m_owner] = '{ready: 1'b1, rdata: 32'h0, error: 1'b1};
        e_req.valid    = 1'b0;
        e_to           = 1'b1;
        n_owner = -1; n_last = m_owner; m_done = m_owner;
      end else begin
        n_cnt = m_cnt + 1;
      end
`endif
    end
    obs_gnt = grant;
    if (tout) to_seen++;
    check_eq("grant", 128'(grant), 128'(e_gnt));
    check_eq("busy", 128'(busy), 128'(e_busy));
    check_eq("timeout", 128'(tout), 128'(e_to));
    check_eq("aopb_req", 128'(aopb_req), 128'(e_req));
    check_eq("spc_rsp", 128'(spc_rsp), 128'(e_rsp));
    @(posedge clk_gen);
    #1;
    m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
  endtask

  task automatic new_req(input int i);
    spc_req[i] = '{valid: 1'b1, write: 1'($urandom_range(1, 0)), addr: $urandom,
                   wdata: $urandom, wstrb: 4'($urandom)};
  endtask

  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (spc_req[i].valid) begin
        if (m_done == i) begin
          if ($urandom_range(1, 0) == 1) new_req(i);
          else spc_req[i].valid = 1'b0;
        end else if (m_owner == i && $urandom_range(19, 0) == 0) begin
          spc_req[i].valid = 1'b0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        new_req(i);
      end
    end
    aopb_rsp = '{ready: ($urandom_range(2, 0) == 0), rdata: $urandom,
                 error: 1'($urandom_range(1, 0))};
  endtask

  initial begin
    logic [N-1:0] exp_seq [8];
    exp_seq = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010};
    to_seen  = 0;
    rst_n    = 1'b0;
    spc_req  = '0;
    aopb_rsp = '0;
    model_reset();
    #1;
    check_eq("rst_grant", 128'(grant), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_timeout", 128'(tout), 128'(0));
    check_eq("rst_aopb_req", 128'(aopb_req), 128'(0));
    check_eq("rst_spc_rsp", 128'(spc_rsp), 128'(0));
    @(posedge clk_gen);
    #1 rst_n = 1'b1;

    // Single read from master 0, slave ready two cycles after valid.
    spc_req[0] = '{valid: 1'b1, write: 1'b0, addr: 32'h40, wdata: 32'h0, wstrb: 4'h0};
    aopb_rsp   = '{ready: 1'b0, rdata: 32'hCAFE_0001, error: 1'b0};
    step();
    #1 check_eq("single_grant", 128'(grant), 128'(3'b001));
    step();
    aopb_rsp.ready = 1'b1;
    #1 check_eq("single_rdata", 128'(spc_rsp[0].rdata), 128'(32'hCAFE_0001));
    check_eq("single_ready", 128'(spc_rsp[0].ready), 128'(1));
    step();
    #1 check_eq("single_idle", 128'(busy), 128'(0));
    spc_req[0].valid = 1'b0;
    aopb_rsp.ready   = 1'b0;
    step();

    // Master 1 owns the bus; master 0 must wait for it to finish.
    new_req(1);
    step();
    new_req(0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("wait_m0_ready", 128'(spc_rsp[0].ready), 128'(0));
    end
    aopb_rsp.ready = 1'b1;
    step();
    spc_req[1].valid = 1'b0;
    step();
    #1 check_eq("m0_after_m1", 128'(grant), 128'(3'b001));
    step();
    spc_req[0].valid = 1'b0;
    aopb_rsp.ready   = 1'b0;
    step();

    // Slave never ready: watchdog fires on the 5th GRANT cycle when built in.
    to_seen = 0;
    new_req(0);
    repeat (6) step();
`ifdef AO_SPC_ARB_TIMEOUT_EN
    check_eq("timeout_pulses", 128'(to_seen), 128'(1));
`else
    check_eq("timeout_pulses", 128'(to_seen), 128'(0));
    check_eq("grant_persists", 128'(busy), 128'(1));
`endif
    spc_req[0].valid = 1'b0;
    repeat (2) step();

    // Reset in the middle of a transfer.
    new_req(0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_grant", 128'(grant), 128'(0));
    check_eq("midrst_busy", 128'(busy), 128'(0));
    check_eq("midrst_aopb", 128'(aopb_req), 128'(0));
    check_eq("midrst_rsp", 128'(spc_rsp), 128'(0));
    model_reset();
    @(posedge clk_gen);
    #1 rst_n = 1'b1;

    // Masters 0 and 1 continuously valid, slave always ready: grants alternate.
    new_req(1);
    aopb_rsp.ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      step();
      check_eq("alternate", 128'(obs_gnt), 128'(exp_seq[s]));
    end

    spc_req  = '0;
    aopb_rsp = '0;
    step();
    step();
    for (int it = 0; it < 400; it++) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
